// File: rtl/rshift_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rshift_round_pipe
// Purpose  : Pipelined arithmetic right shifter (floor / toward-zero /
//            round-half-up) with valid/ready flow control on both sides.
//            Optional macro RSHIFT_STICKY_EN adds the out_inexact flag.
// Revision : 1.0
// ============================================================================
module rshift_round_pipe #(
   parameter int WIDTH = 9,
   parameter int SH_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SH_W-1:0]  in_shift,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef RSHIFT_STICKY_EN
   ,
   output logic             out_inexact
`endif
);

   localparam int c_LAST = SH_W - 1;

   logic             en;
   logic             out_valid_d, out_valid_q;
   logic [WIDTH-1:0] out_data_d, out_data_q;

   assign en        = out_ready | ~out_valid_q;
   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   genvar k;
   generate
      for (k = 0; k < SH_W; k++) begin : g_stage
         localparam int c_AMT = 1 << k;
         // Shift bits not yet applied, this stage's bit in position 0.
         localparam int c_REM = SH_W - k;

         logic             src_vld, src_g, src_s;
         logic [WIDTH-1:0] src_data;
         logic [1:0]       src_mode;
         logic [c_REM-1:0] src_rem;

         if (k == 0) begin : g_first
            assign src_vld  = in_valid;
            assign src_data = in_data;
            assign src_mode = (in_mode == 2'd3) ? 2'd0 : in_mode;
            assign src_rem  = in_shift;
            assign src_g    = 1'b0;
            assign src_s    = 1'b0;
         end else begin : g_next
            assign src_vld  = g_stage[k-1].vld_q;
            assign src_data = g_stage[k-1].data_q;
            assign src_mode = g_stage[k-1].mode_q;
            assign src_rem  = g_stage[k-1].g_rem.rem_q;
            assign src_g    = g_stage[k-1].g_q;
            assign src_s    = g_stage[k-1].s_q;
         end

         logic [WIDTH+c_AMT-1:0] wide;
         logic                   lost_lo;

         assign wide = {{c_AMT{src_data[WIDTH-1]}}, src_data};

         if (c_AMT > 1) begin : g_lo
            assign lost_lo = |wide[c_AMT-2:0];
         end else begin : g_no_lo
            assign lost_lo = 1'b0;
         end

         logic             vld_d, vld_q, g_d, g_q, s_d, s_q;
         logic [WIDTH-1:0] data_d, data_q;
         logic [1:0]       mode_d, mode_q;

         // Earlier guard/sticky are lower-order than anything shifted out now.
         always_comb begin
            vld_d  = src_vld;
            mode_d = src_mode;
            data_d = src_data;
            g_d    = src_g;
            s_d    = src_s;
            if (src_rem[0]) begin
               data_d = wide[c_AMT +: WIDTH];
               g_d    = wide[c_AMT-1];
               s_d    = src_g | src_s | lost_lo;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_q  <= 1'b0;
               data_q <= '0;
               mode_q <= 2'd0;
               g_q    <= 1'b0;
               s_q    <= 1'b0;
            end else if (en) begin
               vld_q  <= vld_d;
               data_q <= data_d;
               mode_q <= mode_d;
               g_q    <= g_d;
               s_q    <= s_d;
            end
         end

         if (c_REM > 1) begin : g_rem
            logic [c_REM-2:0] rem_d, rem_q;

            always_comb begin
               rem_d = src_rem[c_REM-1:1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  rem_q <= '0;
               end else if (en) begin
                  rem_q <= rem_d;
               end
            end
         end
      end
   endgenerate

   logic [WIDTH-1:0] fl;
   logic             fl_vld, fl_g, fl_s, inc;
   logic [1:0]       fl_mode;

   assign fl      = g_stage[c_LAST].data_q;
   assign fl_vld  = g_stage[c_LAST].vld_q;
   assign fl_g    = g_stage[c_LAST].g_q;
   assign fl_s    = g_stage[c_LAST].s_q;
   assign fl_mode = g_stage[c_LAST].mode_q;

   // Increment only happens for shift >= 1, so it cannot overflow.
   always_comb begin
      inc = 1'b0;
      case (fl_mode)
         2'd1:    inc = fl[WIDTH-1] & (fl_g | fl_s);
         2'd2:    inc = fl_g;
         default: inc = 1'b0;
      endcase
      out_valid_d = fl_vld;
      out_data_d  = fl + {{(WIDTH-1){1'b0}}, inc};
   end

`ifdef RSHIFT_STICKY_EN
   logic inexact_d, inexact_q;

   always_comb begin
      inexact_d = fl_g | fl_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         inexact_q   <= 1'b0;
      end else if (en) begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         inexact_q   <= inexact_d;
      end
   end

   assign out_inexact = inexact_q;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (en) begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rshift_round_pipe.sv
`default_nettype none
// Testbench for rshift_round_pipe: random + directed stimulus, scoreboard
// against an arithmetic reference model.
module tb_rshift_round_pipe;
   localparam int WIDTH = 9;
   localparam int SH_W  = 4;
   localparam int LAT   = SH_W + 1;

   logic             clk = 1'b0;
   logic             rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [WIDTH-1:0] in_data, out_data;
   logic [SH_W-1:0]  in_shift;
   logic [1:0]       in_mode;
`ifdef RSHIFT_STICKY_EN
   logic             out_inexact;
`endif

   rshift_round_pipe #(.WIDTH(WIDTH), .SH_W(SH_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shift  (in_shift),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef RSHIFT_STICKY_EN
      ,
      .out_inexact (out_inexact)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit strict_lat = 1'b0;
   bit rnd_done   = 1'b0;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             inexact;
      int               t;
   } exp_t;

   exp_t sbq[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Reference: real-valued x / 2^s reduced with integer arithmetic.
   function automatic exp_t model(input logic [WIDTH-1:0] d, input logic [SH_W-1:0] sh,
                                  input logic [1:0] mode);
      exp_t   m;
      longint x, p, fl, rem, res;
      x   = longint'($signed(d));
      p   = 64'sd1 <<< sh;
      fl  = x >>> sh;
      rem = x - fl * p;
      res = fl;
      if (mode == 2'd1 && x < 0 && rem != 0) res = res + 1;
      if (mode == 2'd2 && sh != 0 && 2 * rem >= p) res = res + 1;
      m.data    = res[WIDTH-1:0];
      m.inexact = (rem != 0);
      m.t       = 0;
      return m;
   endfunction

   always @(negedge clk) begin
      if (rst_n === 1'b1 && in_valid && in_ready) begin
         exp_t e;
         e   = model(in_data, in_shift, in_mode);
         e.t = cyc;
         sbq.push_back(e);
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            check("unexpected_out", {31'd0, out_valid}, 32'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("out_data", {23'd0, out_data}, {23'd0, e.data});
`ifdef RSHIFT_STICKY_EN
            check("out_inexact", {31'd0, out_inexact}, {31'd0, e.inexact});
`endif
            if (strict_lat) check("latency", cyc - e.t, LAT);
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] d, input logic [SH_W-1:0] sh, input logic [1:0] mode);
      bit acc = 1'b0;
      int n   = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_shift = sh;
      in_mode  = mode;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) check("send_accept", {31'd0, acc}, 32'd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_rand();
      logic [31:0] r;
      r = $urandom;
      send(r[WIDTH-1:0], r[WIDTH+SH_W-1:WIDTH], r[WIDTH+SH_W+1:WIDTH+SH_W]);
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 1'b0;
      while (sbq.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_empty", sbq.size(), 32'd0);
   endtask

   initial begin
      logic [WIDTH-1:0] held;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shift  = '0;
      in_mode   = 2'd0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {23'd0, out_data}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef RSHIFT_STICKY_EN
      check("rst_inexact", {31'd0, out_inexact}, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      // Directed values, exact latency enforced.
      strict_lat = 1'b1;
      send(9'h100, 4'd3, 2'd0);
      idle(8);
      send(9'h1FB, 4'd1, 2'd0);
      send(9'h1FB, 4'd1, 2'd1);
      send(9'h1FB, 4'd1, 2'd2);
      send(9'h007, 4'd1, 2'd2);
      send(9'h1FF, 4'd12, 2'd0);
      send(9'h1FF, 4'd12, 2'd1);
      send(9'h1FF, 4'd12, 2'd2);
      send(9'h0FF, 4'd12, 2'd0);
      send(9'h0FF, 4'd12, 2'd2);
      send(9'h1FB, 4'd1, 2'd3);
      send(9'h100, 4'd9, 2'd1);
      send(9'h0C0, 4'd9, 2'd2);
      send(9'h0AB, 4'd0, 2'd2);
      drain();

      // Back-to-back streaming of 8.
      for (int i = 0; i < 8; i++) send_rand();
      drain();
      strict_lat = 1'b0;

      // Backpressure with a full pipeline.
      for (int i = 0; i < 6; i++) send_rand();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      held = out_data;
      for (int i = 0; i < 4; i++) begin
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         check("stall_out_valid", {31'd0, out_valid}, 32'd1);
         check("stall_out_data", {23'd0, out_data}, {23'd0, held});
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();

      // Random traffic with random downstream stalls.
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               send_rand();
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            in_valid = 1'b0;
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with three transactions in flight.
      for (int i = 0; i < 3; i++) send_rand();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_out_data", {23'd0, out_data}, 32'd0);
      sbq.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         check("postrst_stale", {31'd0, out_valid}, 32'd0);
         @(negedge clk);
      end

      // Pipeline still usable after reset.
      @(posedge clk);
      #1;
      strict_lat = 1'b1;
      send(9'h1FB, 4'd1, 2'd2);
      for (int i = 0; i < 4; i++) send_rand();
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
